// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer: LOAD/EXEC/MEMWAIT microsequencer.
// Optional single-step gating via SEQ_STEP_EN (adds STEP input).
module cs_address_sequencer #(
   parameter int DATAWIDTH_BUS_ADDRESS = 11,
   parameter int DATAWIDTH_BUS_WORD    = 41,
   parameter int DATAWIDTH_IR          = 32
) (
   input  logic                             CLK,
   input  logic                             RESET_InHigh,
   input  logic [DATAWIDTH_BUS_WORD-1:0]    MIR_WORD,
   input  logic [DATAWIDTH_IR-1:0]          IR,
   input  logic                             PSR_N,
   input  logic                             PSR_Z,
   input  logic                             PSR_V,
   input  logic                             PSR_C,
   input  logic                             MEM_ACK,
`ifdef SEQ_STEP_EN
   input  logic                             STEP,
`endif
   output logic [DATAWIDTH_BUS_ADDRESS-1:0] ADDRESS,
   output logic                             EXEC_Valid
);

   localparam int AW = DATAWIDTH_BUS_ADDRESS;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      EXEC    = 2'd1,
      MEMWAIT = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] csar_q;
   logic [AW-1:0] csar_d;

   logic [AW-1:0] addr_f;
   logic [2:0]    cond_f;
   logic          rd_f;
   logic          wr_f;
   logic          mem_req;
   logic          step;
   logic [10:0]   dec11;
   logic [AW-1:0] dec_addr;
   logic [AW-1:0] inc_addr;
   logic [AW-1:0] next_addr;
   logic          unused_w;

   assign addr_f  = MIR_WORD[AW-1:0];
   assign cond_f  = MIR_WORD[13:11];
   assign rd_f    = MIR_WORD[19];
   assign wr_f    = MIR_WORD[18];
   assign mem_req = rd_f | wr_f;

`ifdef SEQ_STEP_EN
   assign step = STEP;
`else
   assign step = 1'b1;
`endif

   // Opcode dispatch: op in [31:30], op3 in [24:19], 4-word slots
   assign dec11    = {1'b1, IR[31:30], IR[24:19], 2'b00};
   assign dec_addr = AW'(dec11);
   assign inc_addr = csar_q + AW'(1);

   assign unused_w = ^{MIR_WORD[DATAWIDTH_BUS_WORD-1:20],
                       MIR_WORD[17:14],
                       IR[29:25], IR[18:14], IR[12:0]};

   always_comb begin
      next_addr = inc_addr;
      unique case (cond_f)
         3'b000: next_addr = inc_addr;
         3'b001: next_addr = PSR_N ? addr_f : inc_addr;
         3'b010: next_addr = PSR_Z ? addr_f : inc_addr;
         3'b011: next_addr = PSR_V ? addr_f : inc_addr;
         3'b100: next_addr = PSR_C ? addr_f : inc_addr;
         3'b101: next_addr = IR[13] ? addr_f : inc_addr;
         3'b110: next_addr = addr_f;
         3'b111: next_addr = dec_addr;
         default: next_addr = inc_addr;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      csar_d     = csar_q;
      EXEC_Valid = 1'b0;
      unique case (state_q)
         LOAD: begin
            state_d = EXEC;
         end
         EXEC: begin
            // A pending memory access outranks the step gate
            if (mem_req && !MEM_ACK) begin
               state_d = MEMWAIT;
            end else if (step) begin
               csar_d     = next_addr;
               EXEC_Valid = 1'b1;
               state_d    = LOAD;
            end
         end
         MEMWAIT: begin
            if (MEM_ACK) begin
               csar_d     = next_addr;
               EXEC_Valid = 1'b1;
               state_d    = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET_InHigh) begin
      if (RESET_InHigh) begin
         state_q <= LOAD;
         csar_q  <= '0;
      end else begin
         state_q <= state_d;
         csar_q  <= csar_d;
      end
   end

   assign ADDRESS = csar_q;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed bench for cs_address_sequencer: vector table plus
// hand sequences for reset, memory wait and step gating.
module tb_cs_address_sequencer;

   logic        CLK;
   logic        RESET_InHigh;
   logic [40:0] MIR_WORD;
   logic [31:0] IR;
   logic        PSR_N;
   logic        PSR_Z;
   logic        PSR_V;
   logic        PSR_C;
   logic        MEM_ACK;
`ifdef SEQ_STEP_EN
   logic        STEP;
`endif
   logic [10:0] ADDRESS;
   logic        EXEC_Valid;

   int n_chk;
   int n_fail;

   cs_address_sequencer #(
      .DATAWIDTH_BUS_ADDRESS(11),
      .DATAWIDTH_BUS_WORD(41),
      .DATAWIDTH_IR(32)
   ) dut (
      .CLK(CLK),
      .RESET_InHigh(RESET_InHigh),
      .MIR_WORD(MIR_WORD),
      .IR(IR),
      .PSR_N(PSR_N),
      .PSR_Z(PSR_Z),
      .PSR_V(PSR_V),
      .PSR_C(PSR_C),
      .MEM_ACK(MEM_ACK),
`ifdef SEQ_STEP_EN
      .STEP(STEP),
`endif
      .ADDRESS(ADDRESS),
      .EXEC_Valid(EXEC_Valid)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      string       name;
      logic [2:0]  cond;
      logic [10:0] addr;
      logic [31:0] ir;
      logic [3:0]  nzvc;
      logic [10:0] start;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_mir(input logic [2:0] c, input logic [10:0] a,
                          input logic rd, input logic wr);
      logic [40:0] w;
      w        = '0;
      w[40]    = 1'b1;
      w[25:20] = 6'h2A;
      w[17:14] = 4'hF;
      w[10:0]  = a;
      w[13:11] = c;
      w[19]    = rd;
      w[18]    = wr;
      MIR_WORD = w;
   endtask

   task automatic set_flags(input logic [3:0] f);
      PSR_N = f[3];
      PSR_Z = f[2];
      PSR_V = f[1];
      PSR_C = f[0];
   endtask

   // Called at a negedge in LOAD; returns at a negedge in LOAD
   task automatic jump(input logic [10:0] a);
      set_mir(3'b110, a, 1'b0, 1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk("jump_addr", {21'd0, ADDRESS}, {21'd0, a});
      @(negedge CLK);
   endtask

   task automatic run_vec(input vec_t v);
      jump(v.start);
      set_mir(v.cond, v.addr, 1'b0, 1'b0);
      set_flags(~v.nzvc);
      IR = ~v.ir;
      @(posedge CLK);
      @(negedge CLK);
      set_flags(v.nzvc);
      IR = v.ir;
      #1;
      chk({v.name, "_valid"}, {31'd0, EXEC_Valid}, 32'd1);
      @(posedge CLK);
      #1;
      chk(v.name, {21'd0, ADDRESS}, {21'd0, v.exp});
      @(negedge CLK);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      vecs[0]  = '{"z_taken",  3'b010, 11'd12,   32'h0,        4'b0100, 11'd8,    11'd12};
      vecs[1]  = '{"z_not",    3'b010, 11'd12,   32'h0,        4'b0000, 11'd8,    11'd9};
      vecs[2]  = '{"decode1",  3'b111, 11'd0,    32'h80800000, 4'b0000, 11'd100,  11'd1600};
      vecs[3]  = '{"wrap",     3'b000, 11'd0,    32'h0,        4'b0000, 11'd2047, 11'd0};
      vecs[4]  = '{"n_taken",  3'b001, 11'd500,  32'h0,        4'b1000, 11'd20,   11'd500};
      vecs[5]  = '{"n_not",    3'b001, 11'd500,  32'h0,        4'b0111, 11'd20,   11'd21};
      vecs[6]  = '{"v_taken",  3'b011, 11'd700,  32'h0,        4'b0010, 11'd30,   11'd700};
      vecs[7]  = '{"v_not",    3'b011, 11'd700,  32'h0,        4'b1101, 11'd30,   11'd31};
      vecs[8]  = '{"c_taken",  3'b100, 11'd700,  32'h0,        4'b0001, 11'd30,   11'd700};
      vecs[9]  = '{"c_not",    3'b100, 11'd700,  32'h0,        4'b1110, 11'd30,   11'd31};
      vecs[10] = '{"ir13_tk",  3'b101, 11'd900,  32'h00002000, 4'b0000, 11'd40,   11'd900};
      vecs[11] = '{"ir13_not", 3'b101, 11'd900,  32'hFFFFDFFF, 4'b1111, 11'd40,   11'd41};
      vecs[12] = '{"uncond",   3'b110, 11'd1234, 32'h0,        4'b0000, 11'd50,   11'd1234};
      vecs[13] = '{"decode2",  3'b111, 11'd0,    32'hC1F80000, 4'b0000, 11'd5,    11'd2044};
      vecs[14] = '{"inc_top",  3'b000, 11'd0,    32'h0,        4'b1111, 11'd2046, 11'd2047};

      RESET_InHigh = 1'b1;
      IR           = '0;
      MEM_ACK      = 1'b0;
`ifdef SEQ_STEP_EN
      STEP         = 1'b1;
`endif
      set_flags(4'b0000);
      set_mir(3'b000, 11'd0, 1'b0, 1'b0);
      #2;
      chk("rst_addr", {21'd0, ADDRESS}, 32'd0);
      chk("rst_valid", {31'd0, EXEC_Valid}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RESET_InHigh = 1'b0;

      // Free-running increment after reset release
      for (int i = 1; i <= 3; i++) begin
         @(posedge CLK);
         #1;
         chk("inc_hold", {21'd0, ADDRESS}, i - 1);
         chk("inc_pulse", {31'd0, EXEC_Valid}, 32'd1);
         @(posedge CLK);
         #1;
         chk("inc_addr", {21'd0, ADDRESS}, i);
         chk("inc_idle", {31'd0, EXEC_Valid}, 32'd0);
      end
      @(negedge CLK);

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i]);
      end

      // Read with delayed acknowledge
      jump(11'd60);
      set_mir(3'b000, 11'd0, 1'b1, 1'b0);
      MEM_ACK = 1'b0;
      @(posedge CLK);
      #1;
      chk("mw_exec_valid", {31'd0, EXEC_Valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         chk("mw_hold_addr", {21'd0, ADDRESS}, 32'd60);
         chk("mw_hold_valid", {31'd0, EXEC_Valid}, 32'd0);
      end
      @(negedge CLK);
      MEM_ACK = 1'b1;
      #1;
      chk("mw_ack_valid", {31'd0, EXEC_Valid}, 32'd1);
      @(posedge CLK);
      #1;
      MEM_ACK = 1'b0;
      chk("mw_ack_addr", {21'd0, ADDRESS}, 32'd61);
      chk("mw_after_valid", {31'd0, EXEC_Valid}, 32'd0);
      @(negedge CLK);

      // Write acknowledged in the EXEC cycle itself
      set_mir(3'b000, 11'd0, 1'b0, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      MEM_ACK = 1'b1;
      #1;
      chk("wr_ack_valid", {31'd0, EXEC_Valid}, 32'd1);
      @(posedge CLK);
      #1;
      MEM_ACK = 1'b0;
      chk("wr_ack_addr", {21'd0, ADDRESS}, 32'd62);
      @(negedge CLK);

      // Asynchronous reset while parked in MEMWAIT
      jump(11'd300);
      set_mir(3'b000, 11'd0, 1'b1, 1'b0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #2;
      RESET_InHigh = 1'b1;
      MEM_ACK      = 1'b1;
      #1;
      chk("mwrst_addr", {21'd0, ADDRESS}, 32'd0);
      chk("mwrst_valid", {31'd0, EXEC_Valid}, 32'd0);
      @(posedge CLK);
      #1;
      chk("mwrst_hold", {21'd0, ADDRESS}, 32'd0);
      @(negedge CLK);
      RESET_InHigh = 1'b0;
      MEM_ACK      = 1'b0;
      set_mir(3'b000, 11'd0, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      chk("post_rst_hold", {21'd0, ADDRESS}, 32'd0);
      chk("post_rst_valid", {31'd0, EXEC_Valid}, 32'd1);
      @(posedge CLK);
      #1;
      chk("post_rst_addr", {21'd0, ADDRESS}, 32'd1);
      @(negedge CLK);

`ifdef SEQ_STEP_EN
      jump(11'd400);
      set_mir(3'b000, 11'd0, 1'b0, 1'b0);
      STEP = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1;
         chk("step_hold_addr", {21'd0, ADDRESS}, 32'd400);
         chk("step_hold_valid", {31'd0, EXEC_Valid}, 32'd0);
      end
      @(negedge CLK);
      STEP = 1'b1;
      #1;
      chk("step_pulse_valid", {31'd0, EXEC_Valid}, 32'd1);
      @(posedge CLK);
      #1;
      STEP = 1'b0;
      chk("step_adv", {21'd0, ADDRESS}, 32'd401);
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         chk("step_after_addr", {21'd0, ADDRESS}, 32'd401);
         chk("step_after_valid", {31'd0, EXEC_Valid}, 32'd0);
      end
      @(negedge CLK);
      STEP = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cs_address_sequencer.md
CS_ADDRESS_SEQUENCER -- requirements
Module: cs_address_sequencer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_BUS_ADDRESS, default 11, meaning the control-store address width.
REQ-002 The block SHALL have parameter DATAWIDTH_BUS_WORD, default 41, meaning the microinstruction width.
REQ-003 The block SHALL have parameter DATAWIDTH_IR, default 32, meaning the instruction register width.
REQ-004 The block SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_InHigh  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port MIR_WORD  input  41  registered microinstruction from the MIR.
REQ-007 The block SHALL have port IR  input  32  current instruction register.
REQ-008 The block SHALL have ports PSR_N, PSR_Z, PSR_V, PSR_C  input  1 each  condition flags.
REQ-009 The block SHALL have port MEM_ACK  input  1  main-memory access complete.
REQ-010 The block SHALL have port ADDRESS  output  11  registered control-store address (CSAR) driven to the MIR.
REQ-011 The block SHALL have port EXEC_Valid  output  1  high for exactly the cycle in which MIR_WORD is committed.

Function
REQ-012 The block SHALL decode MIR_WORD fields as ADDR=[10:0], COND=[13:11], RD=[19], WR=[18].
REQ-013 The FSM SHALL have states LOAD, EXEC and MEMWAIT.
REQ-014 In LOAD, ADDRESS SHALL hold and the FSM SHALL go to EXEC next cycle, giving the MIR one edge to register the word.
REQ-015 In EXEC with RD=0 and WR=0, or MEM_ACK=1, the block SHALL load ADDRESS with the next address, pulse EXEC_Valid, and go to LOAD.
REQ-016 In EXEC with (RD|WR)=1 and MEM_ACK=0, the block SHALL hold ADDRESS, keep EXEC_Valid=0, and go to MEMWAIT.
REQ-017 In MEMWAIT, the block SHALL hold until MEM_ACK=1, then act as REQ-015 in that same cycle.
REQ-018 The next address SHALL be selected by COND: 000 CSAR+1; 001 ADDR if PSR_N else CSAR+1; 010 same with PSR_Z; 011 same with PSR_V; 100 same with PSR_C; 101 same with IR[13]; 110 ADDR unconditionally; 111 decode.
REQ-019 The decode address SHALL be {1'b1, IR[31:30], IR[24:19], 2'b00}.
REQ-020 CSAR+1 SHALL be computed modulo 2^11, so 2047 increments to 0.
REQ-021 The flags and IR SHALL be sampled only in the committing cycle; changes at other times SHALL have no effect.

Reset
REQ-022 Asserting RESET_InHigh SHALL immediately force ADDRESS=0, EXEC_Valid=0 and state=LOAD, in any state including MEMWAIT.
REQ-023 After reset release, the first commit SHALL occur on the second rising edge, executing word 0.

Configuration
REQ-024 With SEQ_STEP_EN defined, the block SHALL add input STEP (1 bit), and the EXEC→LOAD commit SHALL occur only in a cycle with STEP=1.
REQ-025 With SEQ_STEP_EN defined, when STEP=0 in EXEC, the block SHALL remain in EXEC, hold ADDRESS, and keep EXEC_Valid=0; MEMWAIT SHALL still take priority when (RD|WR)=1 and MEM_ACK=0.
REQ-026 Without SEQ_STEP_EN, the STEP port SHALL be absent and the block SHALL behave as if STEP=1.

Verification
REQ-027 Reset, then release with MIR_WORD COND=000 -> ADDRESS 0 for 2 edges, then 1; EXEC_Valid pulses every 2nd cycle; ADDRESS increments 1, 2, 3.
REQ-028 In EXEC with COND=111 and IR=0x80800000 (op=10, op3=010000) -> ADDRESS=1600.
REQ-029 COND=010, ADDR=12, CSAR=8: with PSR_Z=1 -> ADDRESS=12; with PSR_Z=0 -> ADDRESS=9.
REQ-030 RD=1, MEM_ACK=0 for 5 cycles, then 1 -> ADDRESS held and EXEC_Valid=0 through the wait; single EXEC_Valid pulse and ADDRESS update in the ACK cycle.
REQ-031 CSAR=2047 with COND=000 -> ADDRESS=0; RESET_InHigh asserted mid-MEMWAIT -> ADDRESS=0 asynchronously and state=LOAD.
REQ-032 With SEQ_STEP_EN: STEP=0 for 10 cycles -> no commit; a 1-cycle STEP pulse -> exactly one EXEC_Valid pulse and one ADDRESS advance.
